// File: rtl/taillight_seq_pkg.sv
// Shared mode codes and thermometer-mask helpers for the tail-light sequencer.
// The mask helpers build at most MAX_LEDS bits; callers truncate to their bank width.
package taillight_pkg;

    localparam int MODE_W   = 3;
    localparam int MAX_LEDS = 32;

    localparam logic [MODE_W-1:0] MODE_IDLE       = 3'd0;
    localparam logic [MODE_W-1:0] MODE_HAZARDS    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_TURN_LEFT  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_TURN_RIGHT = 3'd3;

    // Low `step` bits of an n-bit bank set: the left side fills outward from bit 0.
    function automatic logic [MAX_LEDS-1:0] fill_lsb(input int step, input int n);
        logic [MAX_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            if (i < n && i < step) m[i] = 1'b1;
        end
        return m;
    endfunction

    // High `step` bits of an n-bit bank set: the right side fills from bit n-1 downward.
    function automatic logic [MAX_LEDS-1:0] fill_msb(input int step, input int n);
        logic [MAX_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            if (i < n && i >= n - step) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/taillight_seq_if.sv
// Mode/brake inputs and lamp-bank outputs of the tail-light sequencer.
interface taillight_seq_if #(
    parameter int LEDS_PER_SIDE = 3
);
    import taillight_pkg::*;

    logic [MODE_W-1:0]        mode;
    logic                     brake;
    logic [LEDS_PER_SIDE-1:0] led_l;
    logic [LEDS_PER_SIDE-1:0] led_r;
    logic [MODE_W-1:0]        mode_code;
    logic                     step_tick;

    modport master (
        output mode, brake,
        input  led_l, led_r, mode_code, step_tick
    );

    modport slave (
        input  mode, brake,
        output led_l, led_r, mode_code, step_tick
    );

endinterface

// File: rtl/taillight_seq_tick_prescaler.sv
// Divides clk down to the animation step rate; clear restarts the count.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int            DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // A clear (mode change) suppresses the tick even when the count is at its last value.
    assign tick = (div_cnt == LAST) && !clear;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (clear || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/taillight_seq.sv
// N-LED tail-light sequencer: turn fill, hazard flash and brake overlay, all outputs registered.
// Supports LEDS_PER_SIDE up to taillight_pkg::MAX_LEDS.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LEDS_PER_SIDE = 3,
    parameter int TICK_DIV      = 1
) (
    input logic            clk,
    input logic            reset_n,
    taillight_seq_if.slave bus
);

    localparam int                       SW        = $clog2(LEDS_PER_SIDE + 1);
    localparam logic [SW-1:0]            STEP_LAST = SW'(LEDS_PER_SIDE);
    localparam logic [LEDS_PER_SIDE-1:0] ALL_ON    = '1;

    logic [MODE_W-1:0]        mode_q;
    logic                     brake_q;
    logic [SW-1:0]            step;
    logic                     phase;
    logic                     mode_change;
    logic                     tick;
    logic                     step_tick_q;
    logic [LEDS_PER_SIDE-1:0] led_l_q, led_r_q;
    logic [LEDS_PER_SIDE-1:0] led_l_d, led_r_d;
    logic [LEDS_PER_SIDE-1:0] brake_mask;

    assign mode_change = (bus.mode != mode_q);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mode_change),
        .tick    (tick)
    );

    // step and phase only advance in their own mode; any mode change returns them to 0,
    // so outside turn/hazard modes they simply stay at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= MODE_IDLE;
            brake_q     <= 1'b0;
            step        <= '0;
            phase       <= 1'b0;
            step_tick_q <= 1'b0;
        end else begin
            mode_q      <= bus.mode;
            brake_q     <= bus.brake;
            step_tick_q <= tick;
            if (mode_change) begin
                step  <= '0;
                phase <= 1'b0;
            end else if (tick) begin
                if (mode_q == MODE_TURN_LEFT || mode_q == MODE_TURN_RIGHT) begin
                    step <= (step == STEP_LAST) ? '0 : step + 1'b1;
                end
                if (mode_q == MODE_HAZARDS) begin
                    phase <= ~phase;
                end
            end
        end
    end

    assign brake_mask = brake_q ? ALL_ON : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        led_l_d = '0;
        led_r_d = '0;
        case (mode_q)
            MODE_HAZARDS: begin
                led_l_d = phase ? ALL_ON : '0;
                led_r_d = phase ? ALL_ON : '0;
            end
            MODE_TURN_LEFT: begin
                led_l_d = LEDS_PER_SIDE'(fill_lsb(int'(step), LEDS_PER_SIDE));
                led_r_d = brake_mask;
            end
            MODE_TURN_RIGHT: begin
                led_l_d = brake_mask;
                led_r_d = LEDS_PER_SIDE'(fill_msb(int'(step), LEDS_PER_SIDE));
            end
            default: begin
                led_l_d = brake_mask;
                led_r_d = brake_mask;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_l_q <= '0;
            led_r_q <= '0;
        end else begin
            led_l_q <= led_l_d;
            led_r_q <= led_r_d;
        end
    end

    assign bus.led_l     = led_l_q;
    assign bus.led_r     = led_r_q;
    assign bus.mode_code = mode_q;
    assign bus.step_tick = step_tick_q;

endmodule
